// File: rtl/conv_mac_accum_if.sv
// Handshake and data bundle between the conv address iterator and the MAC accumulator.
interface conv_mac_accum_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic                     start;
  logic                     cena;
  logic                     first_data;
  logic                     last_data;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] weight_in;
  logic signed [DATA_W-1:0] bias_in;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0]        out_addr;
  logic                     done;
  logic                     busy;

  modport master (
    output start, cena, first_data, last_data, data_in, weight_in, bias_in,
    input  out_valid, out_data, out_addr, done, busy
  );

  modport slave (
    input  start, cena, first_data, last_data, data_in, weight_in, bias_in,
    output out_valid, out_data, out_addr, done, busy
  );
endinterface

// File: rtl/conv_mac_accum.sv
// Convolution MAC accumulator: multiplies pixel/weight pairs over one kernel window,
// adds bias, rounds to fixed point, applies optional ReLU, saturates and emits one
// output pixel with a sequential feature-map write address.
module conv_mac_accum #(
  parameter int DATA_W       = 16,
  parameter int FRAC         = 8,
  parameter int ACC_W        = 40,
  parameter int RD_LATENCY   = 1,
  parameter int OUTPUT_BATCH = 5,
  parameter int OUT_PIXELS   = 576,
  parameter int ADDR_W       = 12,
  parameter int RELU_EN      = 1
) (
  input logic             clk,
  input logic             rst,
  conv_mac_accum_if.slave bus
);

  localparam int PW = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUTPUT_BATCH * OUT_PIXELS - 1);
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // control delay line, aligned with the memory read data at index RD_LATENCY-1
  logic [RD_LATENCY-1:0] dl_v, dl_f, dl_l;
  logic                  a_v, a_f, a_l;

  // S1 product stage
  logic                  p_v, p_f, p_l;
  logic signed [PW-1:0]  p;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] b_sx;

  // S2 accumulate stage
  logic signed [ACC_W-1:0] acc, acc_next, p_sx, sum;
  logic                    res_v;

  // S3 output stage
  logic signed [ACC_W-1:0] rnd_sum, shr;
  logic signed [DATA_W-1:0] res_q;
  logic [ADDR_W-1:0]        cnt;

  assign a_v  = dl_v[RD_LATENCY-1];
  assign a_f  = dl_f[RD_LATENCY-1];
  assign a_l  = dl_l[RD_LATENCY-1];
  assign b_sx = ACC_W'(bus.bias_in);
  assign p_sx = ACC_W'(p);

  // shift beat controls along so they meet the data coming back from memory
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
      dl_f <= '0;
      dl_l <= '0;
    end else begin
      dl_v[0] <= ~bus.cena & ~bus.start;
      dl_f[0] <= bus.first_data;
      dl_l[0] <= bus.last_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_f[i] <= dl_f[i-1];
        dl_l[i] <= dl_l[i-1];
      end
      if (bus.start) dl_v <= '0;
    end
  end

  // S1: register the product, and the pre-scaled bias on last beats
  always_ff @(posedge clk) begin
    if (rst) begin
      p_v   <= 1'b0;
      p_f   <= 1'b0;
      p_l   <= 1'b0;
      p     <= '0;
      b_ext <= '0;
    end else begin
      p_v <= a_v & ~bus.start;
      p_f <= a_f;
      p_l <= a_l;
      if (a_v) p <= PW'(bus.data_in) * PW'(bus.weight_in);
      if (a_v && a_l) b_ext <= b_sx <<< FRAC;
    end
  end

  // next accumulator value; a first beat restarts the window from zero
  always_comb begin
    acc_next = (p_f ? '0 : acc) + p_sx;
  end

  // S2: accumulate, and on the last beat fold in the bias
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      sum   <= '0;
      res_v <= 1'b0;
    end else if (bus.start) begin
      acc   <= '0;
      res_v <= 1'b0;
    end else begin
      res_v <= p_v & p_l;
      if (p_v) begin
        acc <= acc_next;
        if (p_l) sum <= acc_next + b_ext;
      end
    end
  end

  // round half up, optional ReLU, then saturate to the output width
  always_comb begin
    rnd_sum = sum + RND;
    shr     = rnd_sum >>> FRAC;
    res_q   = shr[DATA_W-1:0];
    if (RELU_EN != 0 && shr[ACC_W-1]) begin
      res_q = '0;
    end else if (shr > SAT_MAX) begin
      res_q = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shr < SAT_MIN) begin
      res_q = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  // S3: register the result and its write address, advance the address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.done      <= 1'b0;
      cnt           <= '0;
    end else if (bus.start) begin
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      cnt           <= '0;
    end else begin
      bus.out_valid <= res_v;
      bus.done      <= res_v && (cnt == LAST_ADDR);
      if (res_v) begin
        bus.out_data <= res_q;
        bus.out_addr <= cnt;
        cnt          <= (cnt == LAST_ADDR) ? '0 : cnt + ADDR_W'(1);
      end
    end
  end

  // busy while any valid beat or result remains anywhere in the pipeline
  always_comb begin
    bus.busy = (|dl_v) | p_v | res_v | bus.out_valid;
  end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Self-checking bench for conv_mac_accum: two instances (ReLU on / latency 1 and
// ReLU off / latency 3) share one directed stimulus stream; a window-level model
// predicts each output pixel, its address, done flag and arrival cycle.
module tb_conv_mac_accum;
  localparam int LA = 1;
  localparam int LB = 3;
  localparam int LAST = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        b_start = 1'b0, b_cena = 1'b1, b_first = 1'b0, b_last = 1'b0;
  logic [15:0] b_d = '0, b_w = '0, b_b = '0;
  logic [15:0] hd[4] = '{default: '0};
  logic [15:0] hw[4] = '{default: '0};
  logic [15:0] hb[4] = '{default: '0};

  // memory model: read data returns a fixed number of cycles after the beat
  always @(posedge clk) begin
    hd[0] <= b_d; hw[0] <= b_w; hb[0] <= b_b;
    for (int i = 1; i < 4; i++) begin
      hd[i] <= hd[i-1]; hw[i] <= hw[i-1]; hb[i] <= hb[i-1];
    end
  end

  conv_mac_accum_if #(.DATA_W(16), .ADDR_W(12)) if_a ();
  conv_mac_accum_if #(.DATA_W(16), .ADDR_W(12)) if_b ();

  assign if_a.start = b_start;      assign if_b.start = b_start;
  assign if_a.cena = b_cena;        assign if_b.cena = b_cena;
  assign if_a.first_data = b_first; assign if_b.first_data = b_first;
  assign if_a.last_data = b_last;   assign if_b.last_data = b_last;
  assign if_a.data_in = hd[LA-1];   assign if_b.data_in = hd[LB-1];
  assign if_a.weight_in = hw[LA-1]; assign if_b.weight_in = hw[LB-1];
  assign if_a.bias_in = hb[LA-1];   assign if_b.bias_in = hb[LB-1];

  conv_mac_accum #(.RD_LATENCY(LA), .OUTPUT_BATCH(2), .OUT_PIXELS(3), .RELU_EN(1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  conv_mac_accum #(.RD_LATENCY(LB), .OUTPUT_BATCH(2), .OUT_PIXELS(3), .RELU_EN(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [11:0] addr;
    logic        done;
  } exp_t;

  exp_t    qa[$], qb[$];
  longint  m_acc = 0;
  int      m_addr = 0;
  logic [15:0] last_a, last_b;
  logic [15:0] obs_a = '0, obs_b = '0;
  logic [11:0] oaddr_a = '0, oaddr_b = '0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // fixed-point result of a window sum in Q.16 units
  function automatic logic [15:0] fx(input longint s, input bit relu);
    longint r;
    r = (s + 128) >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic kill();
    while (qa.size() > 0 && qa[$].due > cyc) qa.delete(qa.size() - 1);
    while (qb.size() > 0 && qb[$].due > cyc) qb.delete(qb.size() - 1);
    m_acc = 0;
    m_addr = 0;
  endtask

  task automatic beat(input bit f, input bit l, input logic [15:0] d, w, b);
    exp_t e;
    longint s;
    @(posedge clk); #1;
    rst = 0; b_start = 0; b_cena = 0; b_first = f; b_last = l;
    b_d = d; b_w = w; b_b = b;
    if (f) m_acc = 0;
    m_acc += longint'($signed(d)) * longint'($signed(w));
    if (l) begin
      s = m_acc + (longint'($signed(b)) <<< 8);
      last_a = fx(s, 1'b1);
      last_b = fx(s, 1'b0);
      e.addr = 12'(m_addr);
      e.done = (m_addr == LAST);
      e.due = cyc + LA + 3; e.data = last_a; qa.push_back(e);
      e.due = cyc + LB + 3; e.data = last_b; qb.push_back(e);
      m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
    end
  endtask

  task automatic bubbles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 0; b_start = 0; b_cena = 1;
      b_first = 1'($urandom); b_last = 1'($urandom);
      b_d = 16'($urandom); b_w = 16'($urandom); b_b = 16'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rst = 0; b_start = 0; b_cena = 1; b_first = 0; b_last = 0;
    end
  endtask

  task automatic run_window(input int n, input logic [15:0] d, w, b, input int maxbub);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxbub > 0) bubbles($urandom_range(0, maxbub));
      beat(i == 0, i == n - 1, d, w, b);
    end
  endtask

  task automatic pin(input string nm, input logic [15:0] ea, input logic [15:0] eb);
    chk({nm, "_model_a"}, last_a, ea);
    chk({nm, "_model_b"}, last_b, eb);
  endtask

  // per-cycle comparison of both instances against the model queues
  always @(negedge clk) begin
    if (chk_en) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        chk("a_valid", 16'(if_a.out_valid), 16'd1);
        chk("a_data", if_a.out_data, qa[0].data);
        chk("a_addr", 16'(if_a.out_addr), 16'(qa[0].addr));
        chk("a_done", 16'(if_a.done), 16'(qa[0].done));
        qa.delete(0);
      end else begin
        chk("a_idle_valid", 16'(if_a.out_valid), 16'd0);
        chk("a_idle_done", 16'(if_a.done), 16'd0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        chk("b_valid", 16'(if_b.out_valid), 16'd1);
        chk("b_data", if_b.out_data, qb[0].data);
        chk("b_addr", 16'(if_b.out_addr), 16'(qb[0].addr));
        chk("b_done", 16'(if_b.done), 16'(qb[0].done));
        qb.delete(0);
      end else begin
        chk("b_idle_valid", 16'(if_b.out_valid), 16'd0);
        chk("b_idle_done", 16'(if_b.done), 16'd0);
      end
      if (if_a.out_valid) begin obs_a = if_a.out_data; oaddr_a = if_a.out_addr; end
      if (if_b.out_valid) begin obs_b = if_b.out_data; oaddr_b = if_b.out_addr; end
    end
  end

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_a_valid", 16'(if_a.out_valid), 16'd0);
    chk("rst_a_data", if_a.out_data, 16'h0000);
    chk("rst_a_addr", 16'(if_a.out_addr), 16'd0);
    chk("rst_a_done", 16'(if_a.done), 16'd0);
    chk("rst_a_busy", 16'(if_a.busy), 16'd0);
    chk("rst_b_valid", 16'(if_b.out_valid), 16'd0);
    chk("rst_b_busy", 16'(if_b.busy), 16'd0);
    chk_en = 1;

    run_window(25, 16'h0100, 16'h0200, 16'h0080, 0);
    pin("t1", 16'h3280, 16'h3280);
    idle(8);
    chk("t1_dut_a", obs_a, 16'h3280);
    chk("t1_dut_b", obs_b, 16'h3280);
    chk("t1_addr_a", 16'(oaddr_a), 16'd0);
    chk("t1_addr_b", 16'(oaddr_b), 16'd0);

    run_window(25, 16'h0100, 16'hFE00, 16'h0080, 0);
    pin("t2", 16'h0000, 16'hCE80);
    run_window(25, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
    pin("t3_pos", 16'h7FFF, 16'h7FFF);
    run_window(25, 16'h8000, 16'h7FFF, 16'h7FFF, 0);
    pin("t3_neg", 16'h0000, 16'h8000);

    run_window(1, 16'h0001, 16'h0080, 16'h0000, 0);
    pin("t4_half", 16'h0001, 16'h0001);
    idle(1);
    @(negedge clk);
    chk("busy_a_on", 16'(if_a.busy), 16'd1);
    chk("busy_b_on", 16'(if_b.busy), 16'd1);
    run_window(1, 16'h0001, 16'h007F, 16'h0000, 0);
    pin("t4_below", 16'h0000, 16'h0000);
    idle(10);
    chk("busy_a_off", 16'(if_a.busy), 16'd0);
    chk("busy_b_off", 16'(if_b.busy), 16'd0);

    // window whose output is killed by a start one cycle later; start carries a beat too
    run_window(1, 16'h0100, 16'h0100, 16'h0000, 0);
    @(posedge clk); #1;
    b_start = 1; b_cena = 0; b_first = 1; b_last = 1;
    b_d = 16'h0400; b_w = 16'h0100; b_b = 16'h0000;
    kill();
    idle(2);
    for (int i = 1; i <= 7; i++) begin
      run_window(1, 16'(i << 8), 16'h0100, 16'h0000, 0);
      pin("t5", 16'(i << 8), 16'(i << 8));
    end
    idle(10);

    run_window(9, 16'h0180, 16'h0100, 16'h0040, 2);
    pin("t6_bub", 16'h0DC0, 16'h0DC0);
    idle(10);

    for (int i = 0; i < 10; i++) beat(i == 0, 1'b0, 16'h0300, 16'h0300, 16'h0100);
    @(posedge clk); #1;
    rst = 1; b_start = 0; b_cena = 1; b_first = 0; b_last = 0;
    kill();
    idle(2);
    run_window(25, 16'h0100, 16'h0200, 16'h0080, 0);
    pin("t6_rst", 16'h3280, 16'h3280);
    idle(10);
    chk("t6_dut_a", obs_a, 16'h3280);
    chk("t6_dut_b", obs_b, 16'h3280);
    chk("t6_addr_a", 16'(oaddr_a), 16'd0);
    chk("t6_addr_b", 16'(oaddr_b), 16'd0);

    chk("qa_drained", 16'(qa.size()), 16'd0);
    chk("qb_drained", 16'(qb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
